output_frame_ctrl: RTL and testbench

- Sequences frames of result bytes through the 16-entry output RAM (`ram_output_unit`).
- Drives that RAM's `addr`/`data`/`we` and consumes its `q`.
- Fill phase: accepts a byte stream from the compute pipeline over valid/ready and writes it at ascending addresses.
- Drain phase: reads the frame back in order and presents it downstream over valid/ready.
- Compensates for the RAM's one-cycle registered-address read latency.

---
 rtl/output_pkg.sv | 12 +
 rtl/output_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_output_frame_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/output_pkg.sv
// Shared constants and state encoding for the output frame controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package output_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {FILL, PRIME, DRAIN} out_state_t;

endpackage

// File: rtl/output_frame_ctrl.sv
// Fills a 16-entry output RAM with one frame, then drains it downstream in order.
// Latency: last input accept at T -> first out_valid in cycle T+2; drain 1 byte/cycle.
// Backpressure: in_ready=0 for the whole PRIME/DRAIN phase; out_ready=0 holds the read address.
//
// Ports:
//   clk, rst                         single clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   upstream byte stream (valid/ready)
//   ram_addr/ram_data/ram_we/ram_q   external RAM with registered read address
//   out_data/out_valid/out_last/out_ready  downstream byte stream (valid/ready)
//   frame_len                        byte count of the last closed frame (1..16)
module output_frame_ctrl #(
  parameter int DATA_WIDTH = output_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = output_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   frame_len
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  import output_pkg::*;

  out_state_t            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   len;

  logic in_fire;
  logic out_fire;
  logic at_last;

  // rd_ptr is zero-extended so a 16-byte frame (len=16) compares correctly.
  assign at_last  = ({1'b0, rd_ptr} == (len - (ADDR_WIDTH+1)'(1)));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign frame_len = len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            // The 16th beat closes the frame even without in_last, so the
            // write pointer never wraps within a frame.
            if (in_last || (wr_ptr == ADDR_WIDTH'(DEPTH-1))) begin
              len    <= {1'b0, wr_ptr} + (ADDR_WIDTH+1)'(1);
              wr_ptr <= '0;
              state  <= PRIME;
            end else begin
              wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        PRIME: begin
          rd_ptr <= '0;
          state  <= DRAIN;
        end
        DRAIN: begin
          if (out_fire) begin
            if (at_last) begin
              rd_ptr <= '0;
              state  <= FILL;
            end else begin
              rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_data  = in_data;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = ram_q;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        ram_we   = in_valid;
        ram_addr = wr_ptr;
      end
      PRIME: begin
        // Present address 0 so ram_q holds byte 0 on the first DRAIN cycle.
        ram_addr = '0;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = at_last;
        // Look one address ahead on a handshake so ram_q tracks rd_ptr next
        // cycle; holding the address on a stall keeps out_data stable.
        ram_addr  = out_fire ? (rd_ptr + ADDR_WIDTH'(1)) : rd_ptr;
      end
      default: ;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      ram_we    = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
    end
  end

endmodule

// File: tb/tb_output_frame_ctrl.sv
module tb_output_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic [7:0] ram_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic [4:0] frame_len;

  output_frame_ctrl dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on the edge, read data reflects the address
  // registered at the previous edge.
  logic [7:0] mem [16];
  logic [3:0] addr_q = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: frames are cut at in_last or after 16 bytes.
  typedef struct {
    logic [7:0] d;
    logic       l;
    int         len;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] cur[$];

  function automatic void model_push(input logic [7:0] d, input logic l);
    cur.push_back(d);
    if (l || cur.size() == 16) begin
      for (int i = 0; i < cur.size(); i++)
        exp_q.push_back('{cur[i], (i == cur.size() - 1), cur.size()});
      cur.delete();
    end
  endfunction

  // Downstream stall generator.
  logic stall_en = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor / scoreboard.
  int         popped = 0;
  logic       held_vld = 1'b0;
  logic [7:0] held_dat = '0;
  always @(negedge clk) begin
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (out_valid) chk("no_we_in_drain", {31'd0, ram_we}, 32'd0);
      if (held_vld && out_valid) chk("stall_hold", {24'd0, out_data}, {24'd0, held_dat});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h expected=none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, e.d});
          chk("out_last", {31'd0, out_last}, {31'd0, e.l});
          chk("frame_len", {27'd0, frame_len}, e.len);
          popped++;
        end
      end
      held_vld = out_valid && !out_ready;
      held_dat = out_data;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l,
                           output int waits, output logic [3:0] addr);
    bit done;
    model_push(d, l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waits    = 0;
    addr     = '0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        addr = ram_addr;
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 1000) begin
          $display("FAIL accept_timeout actual=%0d expected<=1000", waits);
          $fatal(1, "input never accepted");
        end
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    int         w;
    logic [3:0] a;
    int         base;
    int         n;

    // Reset: outputs forced low even with in_valid asserted.
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_len", {27'd0, frame_len}, 32'd0);
    @(posedge clk);
    #1;

    // Full 16-byte frame 0x10..0x1F with in_last on the final byte.
    for (int i = 0; i < 16; i++) send_beat(8'(8'h10 + i), (i == 15), w, a);
    chk("len16", {27'd0, frame_len}, 32'd16);
    @(negedge clk);
    chk("prime_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("first_valid_T2", {31'd0, out_valid}, 32'd1);
    wait_drain();

    // 3-byte frame; input reopens the cycle after the last handshake.
    send_beat(8'hA1, 1'b0, w, a);
    send_beat(8'hA2, 1'b0, w, a);
    send_beat(8'hA3, 1'b1, w, a);
    chk("len3", {27'd0, frame_len}, 32'd3);
    wait_drain();
    @(negedge clk);
    chk("in_ready_after_drain", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 16 beats without in_last, then 0x55 must wait out PRIME + 16 drains.
    for (int i = 0; i < 16; i++) send_beat(8'(8'h30 + i), 1'b0, w, a);
    send_beat(8'h55, 1'b1, w, a);
    chk("byte55_wait", w, 32'd17);
    chk("byte55_addr", {28'd0, a}, 32'd0);
    wait_drain();

    // Stalled drain of 0x00..0x07.
    stall_en = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(8'(i), (i == 7), w, a);
    wait_drain();

    // Random frames, lengths above 16 exercise the forced close.
    for (int f = 0; f < 8; f++) begin
      int flen;
      flen = $urandom_range(1, 20);
      for (int i = 0; i < flen; i++) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
        send_beat(8'($urandom), (i == flen - 1), w, a);
      end
      wait_drain();
    end
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset after two bytes of a 5-byte drain.
    base = popped;
    for (int i = 0; i < 5; i++) send_beat(8'(8'hC0 + i), (i == 4), w, a);
    n = 0;
    while (popped < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("mid_drain_reached", popped - base, 32'd2);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_beat(8'hEE, 1'b1, w, a);
    chk("len1", {27'd0, frame_len}, 32'd1);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
